// File: rtl/ws2801_rx.sv
// rtl/ws2801_rx.sv - WS2801 receiver node: captures its own 24-bit pixel, forwards later bits, latches on CKI idle.
// Optional WS2801_RX_STATS_EN adds frame_cnt/pass_cnt statistics outputs.
module ws2801_rx #(
    parameter int FREQ        = 12_500_000,
    parameter int LATCH_US    = 500,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CKI,
    input  logic        SDI,
    output logic        CKO,
    output logic        SDO,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        short_err
`ifdef WS2801_RX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] pass_cnt
`endif
);

    localparam int LATCH_CYCLES = FREQ / 1_000_000 * LATCH_US;
    localparam int IW = $clog2(LATCH_CYCLES + 1);
    localparam logic [IW-1:0] LATCH_VAL = IW'(LATCH_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, PASS} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ck_sh;
    logic [SYNC_STAGES-1:0] sd_sh;
    logic                   ck_prev;
    logic                   fwd;
    logic [23:0]            shadow;
    logic [4:0]             bit_cnt;
    logic [IW-1:0]          idle_cnt;
    logic                   ck_sync;
    logic                   sd_sync;
    logic                   ck_rise;
    logic                   latch_hit;

    assign ck_sync   = ck_sh[SYNC_STAGES-1];
    assign sd_sync   = sd_sh[SYNC_STAGES-1];
    assign ck_rise   = ck_sync & ~ck_prev;
    // Fires only on the increment into LATCH_VAL; saturation keeps it single-shot.
    assign latch_hit = ~ck_sync && (idle_cnt == LATCH_VAL - IW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_sh <= '0;
            sd_sh <= '0;
        end else begin
            ck_sh <= {ck_sh[SYNC_STAGES-2:0], CKI};
            sd_sh <= {sd_sh[SYNC_STAGES-2:0], SDI};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ck_prev   <= 1'b0;
            fwd       <= 1'b0;
            CKO       <= 1'b0;
            SDO       <= 1'b0;
            rgb       <= 24'h0;
            rgb_valid <= 1'b0;
            short_err <= 1'b0;
            shadow    <= 24'h0;
            bit_cnt   <= 5'd0;
            idle_cnt  <= '0;
        end else begin
            rgb_valid <= 1'b0;
            short_err <= 1'b0;
            ck_prev   <= ck_sync;
            // fwd is only set by a rise seen in PASS, so the 24th bit's own clock never reaches CKO.
            CKO       <= ck_prev & fwd;

            if (ck_sync)
                idle_cnt <= '0;
            else if (idle_cnt != LATCH_VAL)
                idle_cnt <= idle_cnt + IW'(1);

            if (latch_hit) begin
                if (bit_cnt == 5'd24) begin
                    rgb       <= shadow;
                    rgb_valid <= 1'b1;
                end else if (bit_cnt != 5'd0) begin
                    short_err <= 1'b1;
                end
                bit_cnt <= 5'd0;
                shadow  <= 24'h0;
                SDO     <= 1'b0;
                fwd     <= 1'b0;
                state   <= IDLE;
            end else if (ck_rise) begin
                case (state)
                    IDLE, SHIFT: begin
                        shadow  <= {shadow[22:0], sd_sync};
                        bit_cnt <= bit_cnt + 5'd1;
                        state   <= (bit_cnt == 5'd23) ? PASS : SHIFT;
                        fwd     <= 1'b0;
                    end
                    PASS: begin
                        SDO <= sd_sync;
                        fwd <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef WS2801_RX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 16'h0;
            pass_cnt  <= 16'h0;
        end else if (latch_hit) begin
            if (bit_cnt == 5'd24)
                frame_cnt <= frame_cnt + 16'd1;
            pass_cnt <= 16'h0;
        end else if (ck_rise && state == PASS && pass_cnt != 16'hFFFF) begin
            pass_cnt <= pass_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ws2801_rx.sv
// tb/tb_ws2801_rx.sv - scoreboard bench for two chained ws2801_rx nodes.
module tb_ws2801_rx;

    localparam int SYNC_STAGES  = 2;
    localparam int LATCH_CYCLES = 12_500_000 / 1_000_000 * 500;

    typedef struct {
        bit          is_short;
        logic [23:0] rgb;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cki = 1'b0;
    logic        sdi = 1'b0;
    logic        cko0, sdo0, v0, se0;
    logic        cko1, sdo1, v1, se1;
    logic [23:0] rgb0, rgb1;
`ifdef WS2801_RX_STATS_EN
    logic [15:0] frame_cnt0, pass_cnt0, frame_cnt1, pass_cnt1;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          v0_cyc   = 0;
    int          v1_cyc   = 0;
    int          cko_rises = 0;
    logic [23:0] fwd_bits = 24'h0;
    logic        cko_prev0 = 1'b0;
    logic        sdo_prev0 = 1'b0;
    logic        pulse_prev0 = 1'b0;
    logic        pulse_prev1 = 1'b0;
    ev_t         q0[$];
    ev_t         q1[$];

    ws2801_rx #(.SYNC_STAGES(SYNC_STAGES)) dut0 (
        .clk(clk), .rst(rst), .CKI(cki), .SDI(sdi), .CKO(cko0), .SDO(sdo0),
        .rgb(rgb0), .rgb_valid(v0), .short_err(se0)
`ifdef WS2801_RX_STATS_EN
        , .frame_cnt(frame_cnt0), .pass_cnt(pass_cnt0)
`endif
    );

    ws2801_rx #(.SYNC_STAGES(SYNC_STAGES)) dut1 (
        .clk(clk), .rst(rst), .CKI(cko0), .SDI(sdo0), .CKO(cko1), .SDO(sdo1),
        .rgb(rgb1), .rgb_valid(v1), .short_err(se1)
`ifdef WS2801_RX_STATS_EN
        , .frame_cnt(frame_cnt1), .pass_cnt(pass_cnt1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int node, input bit is_short, input logic [23:0] val);
        ev_t e;
        e.is_short = is_short;
        e.rgb      = val;
        if (node == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        sdi = b;
        cki = 1'b0;
        repeat (2) @(posedge clk);
        #1 cki = 1'b1;
        repeat (2) @(posedge clk);
        #1 cki = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
    endtask

    task automatic idle_wait();
        repeat (LATCH_CYCLES + SYNC_STAGES + 30) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    // Scoreboard for node 0 plus forwarded-bit capture.
    always @(negedge clk) begin
        if (!rst) begin
            pulse_prev0 <= 1'b0;
            cko_prev0   <= 1'b0;
            sdo_prev0   <= 1'b0;
        end else begin
            if (v0 || se0) begin
                ev_t e;
                chk("n0_pulse_not_back_to_back", pulse_prev0, 1'b0);
                chk("n0_event_expected", q0.size() != 0, 1'b1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("n0_kind", {se0, v0}, {e.is_short, !e.is_short});
                    if (!e.is_short) chk("n0_rgb", rgb0, e.rgb);
                end
                if (v0) v0_cyc = cyc;
            end
            if (cko0 && !cko_prev0) begin
                cko_rises++;
                fwd_bits = {fwd_bits[22:0], sdo0};
                chk("sdo_setup_before_cko", sdo0, sdo_prev0);
            end
            pulse_prev0 <= v0 | se0;
            cko_prev0   <= cko0;
            sdo_prev0   <= sdo0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            pulse_prev1 <= 1'b0;
        end else begin
            if (v1 || se1) begin
                ev_t e;
                chk("n1_pulse_not_back_to_back", pulse_prev1, 1'b0);
                chk("n1_event_expected", q1.size() != 0, 1'b1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("n1_kind", {se1, v1}, {e.is_short, !e.is_short});
                    if (!e.is_short) chk("n1_rgb", rgb1, e.rgb);
                end
                if (v1) v1_cyc = cyc;
            end
            pulse_prev1 <= v1 | se1;
        end
    end

    initial begin
        int lag;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb0", rgb0, 24'h0);
        chk("reset_cko0", cko0, 1'b0);
        chk("reset_sdo0", sdo0, 1'b0);
        chk("reset_valid0", {v0, se0}, 2'b00);
        rst = 1'b1;

        // Single pixel: nothing forwarded.
        cko_rises = 0;
        push(0, 1'b0, 24'h800000);
        send_bits(24'h800000, 24);
        idle_wait();
        chk("t1_rgb0", rgb0, 24'h800000);
        chk("t1_no_cko", cko_rises, 0);
        chk("t1_rgb1_untouched", rgb1, 24'h0);

        // Chained pair, node 1 lags by its own synchronizer plus node 0's retiming.
        push(0, 1'b0, 24'h555555);
        push(1, 1'b0, 24'h000001);
        send_bits(24'h555555, 24);
        send_bits(24'h000001, 24);
        idle_wait();
        chk("t3_rgb0", rgb0, 24'h555555);
        chk("t3_rgb1", rgb1, 24'h000001);
        lag = v1_cyc - v0_cyc;
        chk("t3_valid_lag", (lag >= SYNC_STAGES + 1) && (lag <= SYNC_STAGES + 3), 1'b1);

        // 48 bits: forwarded stream must carry the second word MSB-first.
        cko_rises = 0;
        fwd_bits  = 24'h0;
        push(0, 1'b0, 24'h123456);
        push(1, 1'b0, 24'hABCDEF);
        send_bits(24'h123456, 24);
        send_bits(24'hABCDEF, 24);
        idle_wait();
        chk("t2_rgb0", rgb0, 24'h123456);
        chk("t2_cko_rises", cko_rises, 24);
        chk("t2_fwd_bits", fwd_bits, 24'hABCDEF);
        chk("t2_rgb1", rgb1, 24'hABCDEF);

        // Short frame keeps the old pixel; next full frame recovers.
        push(0, 1'b1, 24'h0);
        send_bits(24'h3FF000, 10);
        idle_wait();
        chk("t4_rgb0_held", rgb0, 24'h123456);
        push(0, 1'b0, 24'hFFFFFF);
        send_bits(24'hFFFFFF, 24);
        idle_wait();
        chk("t4_rgb0_full", rgb0, 24'hFFFFFF);
        chk("t4_rgb1_held", rgb1, 24'hABCDEF);

        // Reset mid-frame discards partial data and clears rgb.
        send_bits(24'hFFF000, 12);
        pulse_reset();
        chk("t5_rgb0_after_reset", rgb0, 24'h0);
        chk("t5_rgb1_after_reset", rgb1, 24'h0);
        push(0, 1'b0, 24'h00FF00);
        send_bits(24'h00FF00, 24);
        idle_wait();
        chk("t5_rgb0", rgb0, 24'h00FF00);

`ifdef WS2801_RX_STATS_EN
        pulse_reset();
        chk("s_frame_cnt_reset", frame_cnt0, 16'd0);
        for (int f = 0; f < 3; f++) begin
            push(0, 1'b0, 24'hA5A5A5);
            push(1, 1'b1, 24'h0);
            send_bits(24'hA5A5A5, 24);
            send_bits(24'hFC0000, 6);
            repeat (20) @(posedge clk);
            #1;
            chk("s_pass_cnt_before", pass_cnt0, 16'd6);
            idle_wait();
            chk("s_pass_cnt_after", pass_cnt0, 16'd0);
            chk("s_frame_cnt", frame_cnt0, 16'(f + 1));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
